// File: rtl/rv32i_mc_pkg.sv
// Shared encodings for the RV32I multicycle control path: FSM states, opcodes,
// ALU op codes and datapath select values.
package rv32i_mc_pkg;

  localparam int unsigned ALU_CTL_W = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned IMM_SEL_W = 3;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_EXEC_U  = 4'd8,
    S_ALU_WB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JAL     = 4'd11,
    S_JALR1   = 4'd12,
    S_JALR2   = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [ALU_CTL_W-1:0] ALU_AND  = 4'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_OR   = 4'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD  = 4'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL  = 4'd3;
  localparam logic [ALU_CTL_W-1:0] ALU_SRL  = 4'd4;
  localparam logic [ALU_CTL_W-1:0] ALU_SRA  = 4'd5;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_SLLI = 4'd8;
  localparam logic [ALU_CTL_W-1:0] ALU_SRLI = 4'd9;
  localparam logic [ALU_CTL_W-1:0] ALU_SRAI = 4'd10;
  localparam logic [ALU_CTL_W-1:0] ALU_XOR  = 4'd11;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT  = 4'd15;

  localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_ZERO   = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic [IMM_SEL_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_SEL_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_SEL_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_SEL_W-1:0] IMM_U = 3'b011;
  localparam logic [IMM_SEL_W-1:0] IMM_J = 3'b100;

  // funct3 010/011 are not defined for conditional branches
  function automatic logic branch_f3_valid(input logic [FUNCT3_W-1:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU op decode from {is_r, funct3, funct7b5}.
module rv32i_alu_decoder
  import rv32i_mc_pkg::*;
(
  input  logic                 is_r,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic                 funct7b5,
  output logic [ALU_CTL_W-1:0] alu_ctl_c
);

  // funct3 selects the operation; funct7b5 splits ADD/SUB (R only) and logical/arith shifts
  always_comb begin
    alu_ctl_c = ALU_ADD;
    case (funct3)
      3'b000:  alu_ctl_c = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ctl_c = is_r ? ALU_SLL : ALU_SLLI;
      3'b010:  alu_ctl_c = ALU_SLT;
      3'b011:  alu_ctl_c = ALU_SLTU;
      3'b100:  alu_ctl_c = ALU_XOR;
      3'b101: begin
        if (is_r) alu_ctl_c = funct7b5 ? ALU_SRA : ALU_SRL;
        else      alu_ctl_c = funct7b5 ? ALU_SRAI : ALU_SRLI;
      end
      3'b110:  alu_ctl_c = ALU_OR;
      3'b111:  alu_ctl_c = ALU_AND;
      default: alu_ctl_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control.sv
// Multicycle main control FSM for the RV32I core. Moore-style outputs decoded
// from state; FETCH enables qualify on mem_ready and BRANCH pc_write on the flags.
// Optional retired-instruction counter: define MC_CTRL_PERF_EN.
module rv32i_mc_control
  import rv32i_mc_pkg::*;
#(
  parameter int unsigned TRAP_ON_SYSTEM = 1
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 n_zero,
  input  logic                 less_than,
  input  logic                 greater_than,
  input  logic                 less_than_u,
  input  logic                 greater_than_u,
  input  logic                 mem_ready,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [SEL_W-1:0]     alu_src_a,
  output logic [SEL_W-1:0]     alu_src_b,
  output logic [SEL_W-1:0]     result_src,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 pc_lsb_clr,
  output logic                 illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]    instret
`endif
);

  state_t                 state_q;
  state_t                 state_nx;
  logic [ALU_CTL_W-1:0]   dec_alu_ctl_c;
  logic                   br_valid_c;
  logic                   br_taken_c;

  rv32i_alu_decoder u_alu_dec (
    .is_r      (state_q == S_EXEC_R),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .alu_ctl_c (dec_alu_ctl_c)
  );

  // Branch condition from ALU flags; undefined funct3 never takes
  always_comb begin
    br_valid_c = branch_f3_valid(funct3);
    br_taken_c = 1'b0;
    case (funct3)
      3'b000:  br_taken_c = zero;
      3'b001:  br_taken_c = n_zero;
      3'b100:  br_taken_c = less_than;
      3'b101:  br_taken_c = greater_than;
      3'b110:  br_taken_c = less_than_u;
      3'b111:  br_taken_c = greater_than_u;
      default: br_taken_c = 1'b0;
    endcase
  end

  // State register, synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEM_ADR;
          OP_R:              state_nx = S_EXEC_R;
          OP_I:              state_nx = S_EXEC_I;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR1;
          OP_LUI, OP_AUIPC:  state_nx = S_EXEC_U;
          OP_FENCE:          state_nx = S_FETCH;
          OP_SYSTEM:         state_nx = (TRAP_ON_SYSTEM != 0) ? S_TRAP : S_FETCH;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEM_ADR: state_nx = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ready) state_nx = S_MEM_WB;
      S_MEM_WB:  state_nx = S_FETCH;
      S_MEM_WR:  if (mem_ready) state_nx = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_U:  state_nx = S_ALU_WB;
      S_ALU_WB:  state_nx = S_FETCH;
      S_BRANCH:  state_nx = br_valid_c ? S_FETCH : S_TRAP;
      S_JAL:     state_nx = S_ALU_WB;
      S_JALR1:   state_nx = S_JALR2;
      S_JALR2:   state_nx = S_ALU_WB;
      S_TRAP:    state_nx = S_TRAP;
      default:   state_nx = S_FETCH;
    endcase
  end

  // Output decode; reset forces the idle pattern regardless of state
  always_comb begin
    alu_ctl    = ALU_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_sel    = IMM_I;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_lsb_clr = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
          imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEM_ADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_sel   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_ctl   = dec_alu_ctl_c;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_ctl   = dec_alu_ctl_c;
        end
        S_EXEC_U: begin
          alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
          imm_sel   = IMM_U;
        end
        S_ALU_WB:  reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_ctl   = ALU_SUB;
          pc_write  = br_valid_c && br_taken_c;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR1: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_JALR2: begin
          alu_src_a  = SRCA_OLD_PC;
          alu_src_b  = SRCB_FOUR;
          pc_write   = 1'b1;
          pc_lsb_clr = 1'b1;
        end
        S_TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic retire_c;

  // Last cycle of each retiring instruction
  always_comb begin
    retire_c = 1'b0;
    case (state_q)
      S_ALU_WB, S_MEM_WB: retire_c = 1'b1;
      S_MEM_WR:           retire_c = mem_ready;
      S_BRANCH:           retire_c = br_valid_c;
      S_DECODE:           retire_c = (opcode == OP_FENCE) ||
                                     ((opcode == OP_SYSTEM) && (TRAP_ON_SYSTEM == 0));
      default:            retire_c = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)         instret <= '0;
    else if (retire_c) instret <= instret + PERF_W'(1);
  end
`endif

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Self-checking bench for rv32i_mc_control: per-cycle expected output vectors
// are queued as stimulus is driven and compared after outputs settle.
// Exercises MC_CTRL_PERF_EN when that macro is defined.
module tb_rv32i_mc_control;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [2:0] imm;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       lsb;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [5:0] fl;
    out_t       e;
  } step_t;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7;
  localparam int EU = 8, AWB = 9, BR = 10, JL = 11, JR1 = 12, JR2 = 13, TR = 14, RST = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero, n_zero, less_than, greater_than, less_than_u, greater_than_u;
  logic       mem_ready;
  logic [3:0] alu_ctl;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_sel;
  logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, pc_lsb_clr, illegal;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret;
`endif

  out_t obs;
  out_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  assign obs = {alu_ctl, alu_src_a, alu_src_b, result_src, imm_sel, adr_src, mem_read,
                mem_write, ir_write, pc_write, reg_write, pc_lsb_clr, illegal};

  rv32i_mc_control dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7b5       (funct7b5),
    .zero           (zero),
    .n_zero         (n_zero),
    .less_than      (less_than),
    .greater_than   (greater_than),
    .less_than_u    (less_than_u),
    .greater_than_u (greater_than_u),
    .mem_ready      (mem_ready),
    .alu_ctl        (alu_ctl),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .result_src     (result_src),
    .imm_sel        (imm_sel),
    .adr_src        (adr_src),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .reg_write      (reg_write),
    .pc_lsb_clr     (pc_lsb_clr),
    .illegal        (illegal)
`ifdef MC_CTRL_PERF_EN
    ,
    .instret        (instret)
`endif
  );

  // Expected outputs for one cycle in state s; x qualifies (mem_ready, JAL, load, LUI, taken)
  function automatic out_t ex(input int s, input logic x, input logic [3:0] op);
    out_t o;
    o = '0;
    o.alu_ctl = 4'd2;
    case (s)
      F:   begin o.mrd = 1'b1; o.b = 2'b10; o.rs = 2'b10; o.irw = x; o.pcw = x; end
      D:   begin o.a = 2'b01; o.b = 2'b01; o.imm = x ? 3'b100 : 3'b010; end
      MA:  begin o.a = 2'b10; o.b = 2'b01; o.imm = x ? 3'b000 : 3'b001; end
      MR:  begin o.mrd = 1'b1; o.adr = 1'b1; end
      MWB: begin o.rw = 1'b1; o.rs = 2'b01; end
      MW:  begin o.mwr = 1'b1; o.adr = 1'b1; end
      ER:  begin o.a = 2'b10; o.alu_ctl = op; end
      EI:  begin o.a = 2'b10; o.b = 2'b01; o.alu_ctl = op; end
      EU:  begin o.a = x ? 2'b11 : 2'b01; o.b = 2'b01; o.imm = 3'b011; end
      AWB: o.rw = 1'b1;
      BR:  begin o.a = 2'b10; o.alu_ctl = 4'd6; o.pcw = x; end
      JL:  begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; end
      JR1: begin o.a = 2'b10; o.b = 2'b01; end
      JR2: begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; o.lsb = 1'b1; end
      TR:  o.ill = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic step_t st(input logic mr, input int s, input logic x = 1'b0,
                               input logic [3:0] op = 4'd2, input logic [5:0] fl = 6'd0);
    step_t r;
    r.rst = (s == RST);
    r.mr  = mr;
    r.fl  = fl;
    r.e   = ex(s, x, op);
    return r;
  endfunction

  // Drive one cycle of stimulus and queue its expected outputs
  task automatic apply(input step_t s);
    reset     = s.rst;
    mem_ready = s.mr;
    {zero, n_zero, less_than, greater_than, less_than_u, greater_than_u} = s.fl;
    sb.push_back(s.e);
  endtask

  task automatic test_reset();
    step_t p[$];
    out_t  e;
    repeat (3) p.push_back(st(1'b1, RST));
    p.push_back(st(1'b0, F));
    p.push_back(st(1'b0, F));
    foreach (p[i]) begin
      apply(p[i]); #1;
      e = sb.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset step %0d: got %h want %h", i, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_r_alu();
    logic [7:0] tbl [5];
    tbl = '{{3'd0, 1'b1, 4'd6}, {3'd0, 1'b0, 4'd2}, {3'd4, 1'b0, 4'd11},
            {3'd5, 1'b1, 4'd5}, {3'd2, 1'b0, 4'd15}};
    foreach (tbl[k]) begin
      step_t p[$];
      out_t  e;
      opcode = 7'b0110011; funct3 = tbl[k][7:5]; funct7b5 = tbl[k][4];
      p.push_back(st(1'b1, F, 1'b1));
      p.push_back(st(1'b1, D));
      p.push_back(st(1'b1, ER, 1'b0, tbl[k][3:0]));
      p.push_back(st(1'b1, AWB));
      foreach (p[i]) begin
        apply(p[i]); #1;
        e = sb.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL r_alu %0d step %0d: got %h want %h", k, i, obs, e); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_i_alu();
    logic [7:0] tbl [6];
    tbl = '{{3'd5, 1'b1, 4'd10}, {3'd5, 1'b0, 4'd9}, {3'd1, 1'b0, 4'd8},
            {3'd3, 1'b0, 4'd7}, {3'd6, 1'b0, 4'd1}, {3'd7, 1'b1, 4'd0}};
    foreach (tbl[k]) begin
      step_t p[$];
      out_t  e;
      opcode = 7'b0010011; funct3 = tbl[k][7:5]; funct7b5 = tbl[k][4];
      p.push_back(st(1'b1, F, 1'b1));
      p.push_back(st(1'b1, D));
      p.push_back(st(1'b1, EI, 1'b0, tbl[k][3:0]));
      p.push_back(st(1'b1, AWB));
      foreach (p[i]) begin
        apply(p[i]); #1;
        e = sb.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL i_alu %0d step %0d: got %h want %h", k, i, obs, e); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_mem();
    step_t p[$];
    out_t  e;
    opcode = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    p.push_back(st(1'b1, F, 1'b1));
    p.push_back(st(1'b1, D));
    p.push_back(st(1'b1, MA, 1'b1));
    repeat (3) p.push_back(st(1'b0, MR));
    p.push_back(st(1'b1, MR));
    p.push_back(st(1'b1, MWB));
    foreach (p[i]) begin
      apply(p[i]); #1;
      e = sb.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL load step %0d: got %h want %h", i, obs, e); end
      @(negedge clk);
    end
    p.delete();
    opcode = 7'b0100011;
    p.push_back(st(1'b1, F, 1'b1));
    p.push_back(st(1'b0, D));
    p.push_back(st(1'b0, MA, 1'b0));
    p.push_back(st(1'b0, MW));
    p.push_back(st(1'b1, MW));
    p.push_back(st(1'b0, F));
    foreach (p[i]) begin
      apply(p[i]); #1;
      e = sb.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL store step %0d: got %h want %h", i, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [9:0] tbl [5];
    // {funct3, flags{z,nz,lt,ge,ltu,geu}, taken}
    tbl = '{{3'b110, 6'b010010, 1'b1}, {3'b110, 6'b010001, 1'b0}, {3'b101, 6'b010101, 1'b1},
            {3'b001, 6'b100001, 1'b0}, {3'b000, 6'b100001, 1'b1}};
    opcode = 7'b1100011; funct7b5 = 1'b0;
    foreach (tbl[k]) begin
      step_t p[$];
      out_t  e;
      funct3 = tbl[k][9:7];
      p.push_back(st(1'b1, F, 1'b1, 4'd2, tbl[k][6:1]));
      p.push_back(st(1'b1, D, 1'b0, 4'd2, tbl[k][6:1]));
      p.push_back(st(1'b1, BR, tbl[k][0], 4'd2, tbl[k][6:1]));
      foreach (p[i]) begin
        apply(p[i]); #1;
        e = sb.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL branch %0d step %0d: got %h want %h", k, i, obs, e); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [5];
    ops = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    funct3 = 3'd0; funct7b5 = 1'b0;
    foreach (ops[k]) begin
      step_t p[$];
      out_t  e;
      opcode = ops[k];
      p.push_back(st(1'b1, F, 1'b1));
      p.push_back(st(1'b1, D, (k == 0)));
      case (k)
        0: begin p.push_back(st(1'b1, JL)); p.push_back(st(1'b1, AWB)); end
        1: begin p.push_back(st(1'b1, JR1)); p.push_back(st(1'b1, JR2)); p.push_back(st(1'b1, AWB)); end
        2: begin p.push_back(st(1'b1, EU, 1'b1)); p.push_back(st(1'b1, AWB)); end
        3: begin p.push_back(st(1'b1, EU, 1'b0)); p.push_back(st(1'b1, AWB)); end
        default: p.push_back(st(1'b0, F));
      endcase
      foreach (p[i]) begin
        apply(p[i]); #1;
        e = sb.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL b2b op%0d step %0d: got %h want %h", k, i, obs, e); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t p[$];
    out_t  e;
    opcode = 7'b0000011; funct3 = 3'd0;
    p.push_back(st(1'b1, F, 1'b1));
    p.push_back(st(1'b1, D));
    p.push_back(st(1'b1, MA, 1'b1));
    p.push_back(st(1'b0, MR));
    p.push_back(st(1'b1, RST));
    p.push_back(st(1'b0, F));
    foreach (p[i]) begin
      apply(p[i]); #1;
      e = sb.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset_mid step %0d: got %h want %h", i, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    logic [9:0] tbl [3];
    // {opcode, funct3}
    tbl = '{{7'b1100011, 3'b010}, {7'b1111111, 3'b000}, {7'b1110011, 3'b000}};
    foreach (tbl[k]) begin
      step_t p[$];
      out_t  e;
      opcode = tbl[k][9:3]; funct3 = tbl[k][2:0];
      p.push_back(st(1'b1, F, 1'b1));
      p.push_back(st(1'b1, D));
      if (k == 0) p.push_back(st(1'b1, BR, 1'b0));
      repeat (3) p.push_back(st(1'b1, TR));
      p.push_back(st(1'b1, RST));
      p.push_back(st(1'b0, F));
      foreach (p[i]) begin
        apply(p[i]); #1;
        e = sb.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL trap %0d step %0d: got %h want %h", k, i, obs, e); end
        @(negedge clk);
      end
    end
  endtask

`ifdef MC_CTRL_PERF_EN
  task automatic test_perf();
    logic [11:0] tbl [10];
    int          cq[$];
    int          e;
    // {opcode, funct3, cycles}
    tbl = '{{7'b0110011, 3'd0, 2'd0}, {7'b0010011, 3'd0, 2'd0}, {7'b0110111, 3'd0, 2'd0},
            {7'b0000011, 3'd0, 2'd1}, {7'b0100011, 3'd0, 2'd0}, {7'b1100011, 3'd0, 2'd2},
            {7'b1100011, 3'd1, 2'd2}, {7'b1101111, 3'd0, 2'd0}, {7'b1100111, 3'd0, 2'd1},
            {7'b0001111, 3'd0, 2'd3}};
    zero = 1'b0; n_zero = 1'b0; less_than = 1'b0; greater_than = 1'b0;
    less_than_u = 1'b0; greater_than_u = 1'b0;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cq.push_back(0); #1;
    e = cq.pop_front(); vectors++;
    if (instret !== 32'(e)) begin miscompares++; $display("FAIL perf reset: got %0d want %0d", instret, e); end
    foreach (tbl[k]) begin
      int n;
      case (tbl[k][1:0])
        2'd0: n = 4; 2'd1: n = 5; 2'd2: n = 3; default: n = 2;
      endcase
      opcode = tbl[k][11:5]; funct3 = tbl[k][4:2];
      cq.push_back(k + 1);
      repeat (n) @(negedge clk);
      #1;
      e = cq.pop_front(); vectors++;
      if (instret !== 32'(e)) begin miscompares++; $display("FAIL perf instr %0d: got %0d want %0d", k, instret, e); end
    end
    opcode = 7'b1111111;
    cq.push_back(10);
    repeat (6) @(negedge clk);
    #1;
    e = cq.pop_front(); vectors++;
    if (instret !== 32'(e)) begin miscompares++; $display("FAIL perf trap: got %0d want %0d", instret, e); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    {zero, n_zero, less_than, greater_than, less_than_u, greater_than_u} = 6'd0;
    test_reset();
    test_r_alu();
    test_i_alu();
    test_mem();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    test_trap();
`ifdef MC_CTRL_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
